psr_unit: RTL and testbench

Processor status register for the CR-16 datapath, sitting directly downstream of the ALU. Captures the ALU's C, L, F, Z, N outputs under per-flag write enables, holds the interrupt-enable bit, supports LPR/SPR-style PSR load and read, and evaluates the 4-bit branch/jump/Scond condition code against the registered flags. The controller reads `cond_true` to resolve Bcond/Jcond/Scond.

---
 rtl/cpu_pkg.sv | 84 ++++++++
 rtl/cond_eval.sv | 44 ++++
 rtl/psr_unit.sv | 121 ++++++++++++
 tb/tb_psr_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg
//   Shared CR-16 datapath definitions.
//   - PSR bit positions (C, L, F, Z, N, E)
//   - 4-bit condition codes used by Bcond/Jcond/Scond
//   - Per-flag write-enable bit indices and typical enable masks
//   - Helper that packs the six PSR state bits into a 16-bit PSR image
// ============================================================================
package cpu_pkg;

    // PSR bit positions
    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;
    localparam int PSR_E = 9;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // flag_we bit indices, order {C,L,F,Z,N}
    localparam int FE_C = 4;
    localparam int FE_L = 3;
    localparam int FE_F = 2;
    localparam int FE_Z = 1;
    localparam int FE_N = 0;

    // Typical enable masks
    localparam logic [4:0] FLAGS_ADD  = 5'b10100;  // C, F
    localparam logic [4:0] FLAGS_SUB  = 5'b11111;  // C, L, F, Z, N
    localparam logic [4:0] FLAGS_NONE = 5'b00000;  // logic/shift/MUL

    // Architectural PSR state, MSB-first {E,N,Z,F,L,C}
    typedef struct packed {
        logic e;
        logic n;
        logic z;
        logic f;
        logic l;
        logic c;
    } psr_state_t;

    // Expand the six state bits into a 16-bit PSR image; undefined bits are 0
    function automatic logic [15:0] psr_pack(input psr_state_t s);
        logic [15:0] v;
        v        = 16'h0000;
        v[PSR_C] = s.c;
        v[PSR_L] = s.l;
        v[PSR_F] = s.f;
        v[PSR_Z] = s.z;
        v[PSR_N] = s.n;
        v[PSR_E] = s.e;
        return v;
    endfunction

    // Extract the six state bits from a PSR image
    function automatic psr_state_t psr_unpack(input logic [15:0] v);
        psr_state_t s;
        s.c = v[PSR_C];
        s.l = v[PSR_L];
        s.f = v[PSR_F];
        s.z = v[PSR_Z];
        s.n = v[PSR_N];
        s.e = v[PSR_E];
        return s;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// ============================================================================
// cond_eval
//   Combinational condition-code evaluator, shared by the PSR (Bcond/Jcond)
//   and the Scond writeback path.
//   Ports:
//     flag_c/l/f/z/n  in   registered flags
//     cond            in   4-bit condition code
//     cond_true       out  condition result
// ============================================================================
module cond_eval
    import cpu_pkg::*;
(
    input  logic       flag_c,
    input  logic       flag_l,
    input  logic       flag_f,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic [3:0] cond,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = flag_z;
            COND_NE: cond_true = !flag_z;
            COND_CS: cond_true = flag_c;
            COND_CC: cond_true = !flag_c;
            COND_HI: cond_true = flag_l;
            COND_LS: cond_true = !flag_l;
            COND_GT: cond_true = flag_n;
            COND_LE: cond_true = !flag_n;
            COND_FS: cond_true = flag_f;
            COND_FC: cond_true = !flag_f;
            COND_LO: cond_true = !flag_l && !flag_z;
            COND_HS: cond_true = flag_l || flag_z;
            COND_LT: cond_true = !flag_n && !flag_z;
            COND_GE: cond_true = flag_n || flag_z;
            COND_UC: cond_true = 1'b1;
            default: cond_true = 1'b0;   // COND_NV
        endcase
    end

endmodule

// File: rtl/psr_unit.sv
// ============================================================================
// psr_unit
//   CR-16 processor status register. Captures ALU flags under per-flag
//   enables, holds the interrupt-enable bit E, supports LPR/SPR load/read,
//   and evaluates the condition code against the registered flags.
//
//   Optional feature macro: PSR_SHADOW_EN
//     defined   -> one-deep shadow PSR; int_take saves PSR and clears E,
//                  int_ret restores it.
//     undefined -> int_take/int_ret are ignored (ports kept).
//
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     alu_c/l/f/z/n            ALU flag outputs
//     flag_we[4:0]             per-flag enables {C,L,F,Z,N}
//     psr_we, psr_wdata        PSR load (LPR)
//     psr_rdata                current PSR (SPR), combinational from regs
//     cond, cond_true          condition code and its result
//     int_take, int_ret        exception entry / return pulses
//     int_en                   current E bit
//
//   Write priority: reset > int_take > int_ret > psr_we > flag_we.
// ============================================================================
module psr_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_c,
    input  logic                  alu_l,
    input  logic                  alu_f,
    input  logic                  alu_z,
    input  logic                  alu_n,
    input  logic [4:0]            flag_we,
    input  logic                  psr_we,
    input  logic [DATA_WIDTH-1:0] psr_wdata,
    output logic [DATA_WIDTH-1:0] psr_rdata,
    input  logic [3:0]            cond,
    output logic                  cond_true,
    input  logic                  int_take,
    input  logic                  int_ret,
    output logic                  int_en
);

    psr_state_t psr_q;
    psr_state_t psr_d;
    psr_state_t load_val;
    logic [15:0] psr_img;

    assign load_val = psr_unpack(psr_wdata[15:0]);

`ifdef PSR_SHADOW_EN
    psr_state_t shadow_q;

    always_ff @(posedge clk) begin
        if (reset)
            shadow_q <= '0;
        else if (int_take)
            shadow_q <= psr_q;   // nested take simply overwrites
    end
`endif

    // Next-state selection in priority order (reset handled in the flop)
    always_comb begin
        psr_d = psr_q;
`ifdef PSR_SHADOW_EN
        if (int_take) begin
            // flags untouched, E cleared; same-cycle loads are dropped
            psr_d.e = 1'b0;
        end else if (int_ret) begin
            psr_d = shadow_q;
        end else
`endif
        if (psr_we) begin
            psr_d = load_val;
        end else begin
            if (flag_we[FE_C]) psr_d.c = alu_c;
            if (flag_we[FE_L]) psr_d.l = alu_l;
            if (flag_we[FE_F]) psr_d.f = alu_f;
            if (flag_we[FE_Z]) psr_d.z = alu_z;
            if (flag_we[FE_N]) psr_d.n = alu_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            psr_q <= '0;
        else
            psr_q <= psr_d;
    end

    assign psr_img = psr_pack(psr_q);

    always_comb begin
        psr_rdata       = '0;
        psr_rdata[15:0] = psr_img;
    end

    assign int_en = psr_q.e;

    cond_eval u_cond_eval (
        .flag_c    (psr_q.c),
        .flag_l    (psr_q.l),
        .flag_f    (psr_q.f),
        .flag_z    (psr_q.z),
        .flag_n    (psr_q.n),
        .cond      (cond),
        .cond_true (cond_true)
    );

    // Only the defined PSR bit positions of psr_wdata are consumed
    logic unused_inputs;
`ifdef PSR_SHADOW_EN
    assign unused_inputs = ^{psr_wdata};
`else
    assign unused_inputs = ^{psr_wdata, int_take, int_ret};
`endif

endmodule

// File: tb/tb_psr_unit.sv
module tb_psr_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_c, alu_l, alu_f, alu_z, alu_n;
    logic [4:0]  flag_we;
    logic        psr_we;
    logic [15:0] psr_wdata;
    logic [15:0] psr_rdata;
    logic [3:0]  cond;
    logic        cond_true;
    logic        int_take, int_ret;
    logic        int_en;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psr_unit #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_c     (alu_c),
        .alu_l     (alu_l),
        .alu_f     (alu_f),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .flag_we   (flag_we),
        .psr_we    (psr_we),
        .psr_wdata (psr_wdata),
        .psr_rdata (psr_rdata),
        .cond      (cond),
        .cond_true (cond_true),
        .int_take  (int_take),
        .int_ret   (int_ret),
        .int_en    (int_en)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sweep all 16 conditions; exp_mask bit i is the expected result for cond i
    task automatic check_conds(input string tag, input logic [15:0] exp_mask);
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            check($sformatf("%s_cond%0d", tag, i), {15'b0, cond_true}, {15'b0, exp_mask[i]});
        end
    endtask

    task automatic set_alu(input logic c, input logic l, input logic f, input logic z, input logic n);
        alu_c = c; alu_l = l; alu_f = f; alu_z = z; alu_n = n;
    endtask

    task automatic idle();
        flag_we = 5'b0; psr_we = 1'b0; psr_wdata = 16'h0;
        int_take = 1'b0; int_ret = 1'b0; reset = 1'b0;
    endtask

    // Apply current inputs at the next rising edge, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        set_alu(0, 0, 0, 0, 0);
        cond  = COND_EQ;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_rdata", psr_rdata, 16'h0000);
        check("rst_int_en", {15'b0, int_en}, 16'h0000);
        check_conds("rst", 16'h56AA);

        // SUB-style update: C=1 L=1 F=0 Z=0 N=1, all enables
        set_alu(1, 1, 0, 0, 1);
        flag_we = FLAGS_SUB;
        tick();
        flag_we = 5'b0;
        set_alu(0, 0, 0, 0, 0);
        check("sub_rdata", psr_rdata, 16'h0085);
        check_conds("sub", 16'h6A56);

        // Hold: alu changes with no enables
        set_alu(0, 0, 1, 1, 0);
        tick();
        check("hold_rdata", psr_rdata, 16'h0085);

        // ADD: only C,F enabled; Z=1 from ALU must not land
        set_alu(0, 0, 1, 1, 0);
        flag_we = FLAGS_ADD;
        tick();
        flag_we = 5'b0;
        check("add_rdata", psr_rdata, 16'h00A4);
        cond = COND_EQ; #1;
        check("add_eq", {15'b0, cond_true}, 16'h0000);

        // psr_we beats flag_we; undefined bits ignored
        set_alu(0, 0, 0, 0, 0);
        flag_we   = FLAGS_SUB;
        psr_we    = 1'b1;
        psr_wdata = 16'hFFFF;
        tick();
        idle();
        check("lpr_rdata", psr_rdata, 16'h02E5);
        check("lpr_int_en", {15'b0, int_en}, 16'h0001);

        // Load PSR = C, Z, E
        psr_we    = 1'b1;
        psr_wdata = 16'h0241;
        tick();
        idle();
        check("lpr2_rdata", psr_rdata, 16'h0241);

`ifdef PSR_SHADOW_EN
        // int_take: clear E, keep flags, drop same-cycle flag writes
        set_alu(0, 0, 0, 0, 0);
        flag_we  = FLAGS_SUB;
        int_take = 1'b1;
        tick();
        idle();
        check("take_rdata", psr_rdata, 16'h0041);
        check("take_int_en", {15'b0, int_en}, 16'h0000);

        // Handler clears Z
        flag_we = 5'b00010;
        tick();
        idle();
        check("hdl_rdata", psr_rdata, 16'h0001);

        // Return restores saved PSR
        int_ret = 1'b1;
        tick();
        idle();
        check("ret_rdata", psr_rdata, 16'h0241);
        check("ret_int_en", {15'b0, int_en}, 16'h0001);

        // take + ret together: take wins
        int_take = 1'b1;
        int_ret  = 1'b1;
        tick();
        idle();
        check("both_rdata", psr_rdata, 16'h0041);

        // Nested take overwrites shadow with 0x0041; ret then restores that
        int_take = 1'b1;
        tick();
        idle();
        int_ret = 1'b1;
        tick();
        idle();
        check("nest_rdata", psr_rdata, 16'h0041);
        check("nest_int_en", {15'b0, int_en}, 16'h0000);
`else
        // Without shadow, int_take is ignored and flag writes proceed
        set_alu(0, 0, 0, 0, 0);
        flag_we  = 5'b00010;
        int_take = 1'b1;
        tick();
        idle();
        check("noshd_take_rdata", psr_rdata, 16'h0201);
        check("noshd_take_int_en", {15'b0, int_en}, 16'h0001);

        int_ret = 1'b1;
        tick();
        idle();
        check("noshd_ret_rdata", psr_rdata, 16'h0201);
`endif

        // Reset overrides every pending write on the same edge
        set_alu(1, 1, 1, 1, 1);
        flag_we   = FLAGS_SUB;
        psr_we    = 1'b1;
        psr_wdata = 16'hFFFF;
        int_take  = 1'b1;
        reset     = 1'b1;
        tick();
        idle();
        set_alu(0, 0, 0, 0, 0);
        check("rst_mid_rdata", psr_rdata, 16'h0000);
        check("rst_mid_int_en", {15'b0, int_en}, 16'h0000);
        cond = COND_NE; #1;
        check("rst_mid_ne", {15'b0, cond_true}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
